// File: rtl/io_pkg.sv
// Shared types and default widths for the I/O port sequencer.
package io_pkg;

  localparam int N_ADDR_DEF  = 4;
  localparam int N_PORTS_DEF = 16;
  localparam int DATA_W_DEF  = 4;

  // Transfer sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_ACK,
    DONE
  } io_state_t;

endpackage

// File: rtl/port_select_decoder.sv
// One-hot decoder from a port number to the peripheral select lines.
// The output is all zero whenever the enable is low.
module port_select_decoder
  import io_pkg::*;
#(
  parameter int N_ADDR  = N_ADDR_DEF,
  parameter int N_PORTS = N_PORTS_DEF
) (
  input  logic               i_en,
  input  logic [N_ADDR-1:0]  i_addr,
  output logic [N_PORTS-1:0] o_sel
);

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_sel
      assign o_sel[gi] = i_en && (i_addr == N_ADDR'(gi));
    end
  endgenerate

endmodule

// File: rtl/io_port_sequencer.sv
// Sequences one IN/OUT transfer at a time onto the one-hot I/O port space:
// latch request, setup cycle, fixed-length strobe, bounded ack wait, done.
// All outputs are registered from the next-state decision so they line up
// with the state they belong to.
module io_port_sequencer
  import io_pkg::*;
#(
  parameter int N_ADDR        = N_ADDR_DEF,
  parameter int N_PORTS       = N_PORTS_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               we,
  input  logic [N_ADDR-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  io_rdata,
  input  logic               io_ack,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rdata,
  output logic               timeout_err,
  output logic [N_PORTS-1:0] port_sel,
  output logic               io_we,
  output logic               io_re,
  output logic [DATA_W-1:0]  io_wdata
);

  localparam int SC_W = $clog2(STROBE_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STROBE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  io_state_t r_state;
  io_state_t w_next_state;

  logic               r_we;
  logic [N_ADDR-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [SC_W-1:0]    r_st_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_ack_seen;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout_err;
  logic [N_PORTS-1:0] r_port_sel;
  logic               r_io_we;
  logic               r_io_re;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_timeout_hit;
  logic               w_sel_en;
  logic               w_in_xfer;
  logic [N_PORTS-1:0] w_dec;

  // Next-state decision; the timeout only fires when no ack is present.
  always_comb begin
    w_next_state  = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE:     if (req) w_next_state = SETUP;
      SETUP:    w_next_state = STROBE;
      STROBE: begin
        if (r_st_cnt == SC_LAST) begin
          w_next_state = (r_ack_seen || io_ack) ? DONE : WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (io_ack) begin
          w_next_state = DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_next_state  = DONE;
          w_timeout_hit = 1'b1;
        end
      end
      DONE:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  assign w_sel_en  = (w_next_state == STROBE) || (w_next_state == WAIT_ACK);
  assign w_in_xfer = (r_state == STROBE) || (r_state == WAIT_ACK);

  port_select_decoder #(
    .N_ADDR  (N_ADDR),
    .N_PORTS (N_PORTS)
  ) u_dec (
    .i_en   (w_sel_en),
    .i_addr (r_addr),
    .o_sel  (w_dec)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Request latch, counters, ack tracking, read capture and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_st_cnt      <= '0;
      r_to_cnt      <= '0;
      r_ack_seen    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_port_sel    <= '0;
      r_io_we       <= 1'b0;
      r_io_re       <= 1'b0;
      r_rdata       <= '0;
    end else begin
      if (r_state == IDLE && req) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      // Counters only advance while staying in their own state, so they
      // never pass their terminal value and clear on exit.
      r_st_cnt <= (r_state == STROBE && w_next_state == STROBE)
                  ? r_st_cnt + 1'b1 : '0;
      r_to_cnt <= (r_state == WAIT_ACK && w_next_state == WAIT_ACK)
                  ? r_to_cnt + 1'b1 : '0;
      r_ack_seen <= (r_state == STROBE) ? (r_ack_seen | io_ack) : 1'b0;
      // Only the first ack of a read loads rdata; later acks are ignored.
      if (w_in_xfer && !r_we && io_ack && !r_ack_seen) begin
        r_rdata <= io_rdata;
      end
      r_busy        <= (w_next_state != IDLE);
      r_done        <= (w_next_state == DONE);
      r_timeout_err <= w_timeout_hit;
      r_port_sel    <= w_dec;
      r_io_we       <= w_sel_en & r_we;
      r_io_re       <= w_sel_en & ~r_we;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign timeout_err = r_timeout_err;
  assign port_sel    = r_port_sel;
  assign io_we       = r_io_we;
  assign io_re       = r_io_re;
  assign io_wdata    = r_wdata;

endmodule

// File: tb/tb_io_port_sequencer.sv
// Scoreboard bench for io_port_sequencer: directed cases plus randomized
// transfers, with expectations derived from the transfer timing rules.
module tb_io_port_sequencer;

  localparam int SC = 2;
  localparam int AT = 15;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [3:0]  wdata;
  logic [3:0]  io_rdata;
  logic        io_ack;
  logic        busy;
  logic        done;
  logic [3:0]  rdata;
  logic        timeout_err;
  logic [15:0] port_sel;
  logic        io_we;
  logic        io_re;
  logic [3:0]  io_wdata;

  io_port_sequencer #(
    .N_ADDR        (4),
    .N_PORTS       (16),
    .DATA_W        (4),
    .STROBE_CYCLES (SC),
    .ACK_TIMEOUT   (AT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .io_rdata    (io_rdata),
    .io_ack      (io_ack),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .timeout_err (timeout_err),
    .port_sel    (port_sel),
    .io_we       (io_we),
    .io_re       (io_re),
    .io_wdata    (io_wdata)
  );

  typedef struct {
    int         c0;
    int         done_c;
    logic       we;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic       err;
    logic [3:0] rdata;
  } txn_t;

  txn_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_en = 0;
  logic [3:0] rdata_model = 4'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: derives the expected per-cycle outputs from the head transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        e_busy, e_we, e_re, e_done;
      logic [15:0] e_sel;
      txn_t        t;
      e_busy = 1'b0; e_we = 1'b0; e_re = 1'b0; e_done = 1'b0; e_sel = '0;
      if (sb.size() > 0 && cyc > sb[0].c0) begin
        t = sb[0];
        e_busy = 1'b1;
        if (cyc >= t.c0 + 2 && cyc < t.done_c) begin
          e_sel = 16'(1) << t.addr;
          e_we  = t.we;
          e_re  = ~t.we;
        end
        e_done = (cyc == t.done_c);
        chk("io_wdata", 32'(io_wdata), 32'(t.wdata));
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("port_sel", 32'(port_sel), 32'(e_sel));
      chk("io_we", 32'(io_we), 32'(e_we));
      chk("io_re", 32'(io_re), 32'(e_re));
      chk("done", 32'(done), 32'(e_done));
      if (e_done) begin
        chk("timeout_err", 32'(timeout_err), 32'(t.err));
        chk("rdata", 32'(rdata), 32'(t.rdata));
        $display("txn %s addr=%0d start=%0d done=%0d err=%0b rdata=%h",
                 t.we ? "OUT" : "IN ", t.addr, t.c0, cyc, timeout_err, rdata);
        void'(sb.pop_front());
      end
    end
  end

  // One transfer: ack is either a single pulse at cycle a (relative to the
  // request) or held high from cycle a onwards. Only acks from the first
  // strobe cycle (relative cycle 2) onwards count.
  task automatic run_txn(input logic twe, input logic [3:0] taddr, input logic [3:0] twd,
                         input int a, input bit hold, input logic [3:0] rdv,
                         input bit xreq, input int xrel, input logic [3:0] xaddr);
    txn_t t;
    int   first;
    int   done_rel;
    bit   acked;
    first = hold ? ((a < 2) ? 2 : a) : a;
    acked = (first >= 2) && (first < 2 + SC + AT);
    if (!acked)              done_rel = 2 + SC + AT;
    else if (first < 2 + SC) done_rel = 2 + SC;
    else                     done_rel = first + 1;
    if (acked && !twe) rdata_model = rdv;
    t.c0 = cyc; t.done_c = cyc + done_rel; t.we = twe; t.addr = taddr;
    t.wdata = twd; t.err = !acked; t.rdata = rdata_model;
    sb.push_back(t);
    for (int rel = 0; rel <= done_rel; rel++) begin
      req = (rel == 0) || (xreq && rel == xrel);
      if (rel == 0) begin
        we = twe; addr = taddr; wdata = twd;
      end else if (xreq && rel == xrel) begin
        we = ~twe; addr = xaddr; wdata = 4'($urandom);
      end
      io_ack   = hold ? (rel >= a) : (rel == a);
      io_rdata = (rel == first) ? rdv : 4'($urandom);
      step();
    end
    req = 1'b0;
    io_ack = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      io_ack   = 1'($urandom);
      io_rdata = 4'($urandom);
      step();
    end
    io_ack = 1'b0;
  endtask

  task automatic rand_txn();
    logic twe;
    int   a;
    bit   hold;
    bit   xreq;
    twe  = 1'($urandom);
    hold = ($urandom_range(0, 3) == 0);
    a    = hold ? $urandom_range(0, 20) : $urandom_range(0, 22);
    xreq = ($urandom_range(0, 2) == 0);
    run_txn(twe, 4'($urandom), 4'($urandom), a, hold, 4'($urandom),
            xreq, $urandom_range(1, 4), 4'($urandom));
    gap();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_port_sel"}, 32'(port_sel), 0);
    chk({tag, "_io_we"}, 32'(io_we), 0);
    chk({tag, "_io_re"}, 32'(io_re), 0);
    chk({tag, "_io_wdata"}, 32'(io_wdata), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 4'hF;
    io_rdata = 4'h7; io_ack = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    req = 1'b0; io_ack = 1'b0;
    reset_n = 1'b1;
    step();
    mon_en = 1'b1;

    // Write with ack tied high.
    run_txn(1'b1, 4'd9, 4'hA, 0, 1'b1, 4'h0, 1'b0, 0, 4'd0);
    // Read with late ack.
    run_txn(1'b0, 4'd3, 4'h0, 6, 1'b0, 4'h5, 1'b0, 0, 4'd0);
    // Write timeout to the top port; an IDLE-cycle ack is ignored.
    run_txn(1'b1, 4'd15, 4'h3, 0, 1'b0, 4'h9, 1'b0, 0, 4'd0);
    // Ack on the last WAIT_ACK cycle wins over timeout.
    run_txn(1'b0, 4'd6, 4'h0, 2 + SC + AT - 1, 1'b0, 4'hC, 1'b0, 0, 4'd0);
    // Request while busy is ignored.
    run_txn(1'b1, 4'd2, 4'h4, 5, 1'b0, 4'h0, 1'b1, 3, 4'd1);
    // Single ack pulse on the first strobe cycle only.
    run_txn(1'b0, 4'd0, 4'h0, 2, 1'b0, 4'hB, 1'b0, 0, 4'd0);

    repeat (40) rand_txn();

    // Reset in the middle of a strobe.
    mon_en = 1'b0;
    req = 1'b1; we = 1'b1; addr = 4'd7; wdata = 4'h6; io_ack = 1'b0;
    step();
    req = 1'b0;
    step();
    chk("midrst_sel", 32'(port_sel), 32'h0080);
    chk("midrst_io_we", 32'(io_we), 1);
    reset_n = 1'b0;
    step();
    chk_all_zero("midrst");
    reset_n = 1'b1;
    rdata_model = 4'h0;
    repeat (4) begin
      io_ack = 1'($urandom);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
      step();
    end
    io_ack = 1'b0;
    mon_en = 1'b1;

    run_txn(1'b0, 4'd12, 4'h0, 4, 1'b0, 4'hE, 1'b0, 0, 4'd0);
    repeat (6) rand_txn();
    repeat (2) step();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
